// File: rtl/sp_ram_pkg.sv
// Shared types and defaults for the single-port RAM request adapter.
package sp_ram_pkg;

    // Defaults for the buffer depth and the byte-address span decoded by the macro.
    localparam int RSP_DEPTH_DEFAULT      = 2;
    localparam int RAM_ADDR_WIDTH_DEFAULT = 11;
    localparam int RSP_DATA_WIDTH         = 32;

    // One response as it travels through the fall-through path and the buffer.
    typedef struct packed {
        logic [RSP_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } rsp_t;

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Small response buffer: registered storage, combinational head, wrapping
// pointers and an occupancy counter. Asynchronous active-low reset clears
// pointers and occupancy; storage contents are don't-care when empty.
module sp_ram_rsp_fifo
    import sp_ram_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH_DEFAULT,
    parameter int WIDTH = $bits(rsp_t),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointer advance wraps at DEPTH so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rptr];

    // Storage write at the tail; no reset needed on the data itself.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sp_ram_req_adapter.sv
// Request/response adapter in front of a single-port RAM macro with one cycle
// of read latency. Grants are limited by outstanding responses (in flight plus
// buffered); the N+1 response falls through when the buffer is empty and is
// parked in the buffer otherwise.
// Optional feature: define SP_RAM_ADDR_CHECK_EN to flag requests whose upper
// address bits lie outside the macro (no RAM access, err=1, rdata=0).
module sp_ram_req_adapter
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEFAULT,
    parameter int RSP_DEPTH      = RSP_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

`ifdef SP_RAM_ADDR_CHECK_EN
    localparam bit LP_ADDR_CHECK = 1'b1;
`else
    // Upper bits are simply passed on; the macro wraps them away.
    localparam bit LP_ADDR_CHECK = 1'b0;
`endif

    logic          w_oob;
    logic [CW:0]   w_outstanding;
    logic          w_gnt;
    logic          r_inflight;
    logic          r_inflight_zero;
    logic          r_inflight_err;
    rsp_t          w_rsp;
    rsp_t          w_head;
    rsp_t          w_out;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_rvalid;
    logic          w_push;
    logic          w_pop;

    assign w_oob = LP_ADDR_CHECK & (|addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH]);

    // Outstanding count does not credit a pop happening in the same cycle.
    assign w_outstanding = {{CW{1'b0}}, r_inflight} + {1'b0, w_fifo_count};
    assign w_gnt         = rstn_i & req_i & (w_outstanding < (CW + 1)'(RSP_DEPTH));
    assign gnt_o         = w_gnt;

    // Out-of-range requests are granted but never touch the macro.
    assign ram_en_o    = w_gnt & ~w_oob;
    assign ram_we_o    = ram_en_o & we_i;
    assign ram_addr_o  = addr_i;
    assign ram_be_o    = be_i;
    assign ram_wdata_o = wdata_i;

    // Remember what kind of response the granted request will produce next cycle.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_inflight      <= 1'b0;
            r_inflight_zero <= 1'b0;
            r_inflight_err  <= 1'b0;
        end else begin
            r_inflight      <= w_gnt;
            r_inflight_zero <= we_i | w_oob;
            r_inflight_err  <= w_gnt & w_oob;
        end
    end

    // Form the N+1 response and choose between buffer head and fall-through.
    always_comb begin
        w_rsp.rdata = r_inflight_zero ? '0 : ram_rdata_i;
        w_rsp.err   = r_inflight_err;
        w_out       = w_fifo_empty ? w_rsp : w_head;
    end

    assign w_rvalid = r_inflight | ~w_fifo_empty;
    assign w_pop    = w_rvalid & rready_i;
    // Park the fresh response unless it falls through and is consumed right away.
    assign w_push   = r_inflight & ~(w_fifo_empty & rready_i) & ~w_fifo_full;

    assign rvalid_o = w_rvalid;
    assign rdata_o  = w_rvalid ? w_out.rdata : '0;
    assign err_o    = w_rvalid & w_out.err;

    sp_ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_t)),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .push_i      (w_push),
        .push_data_i (w_rsp),
        .pop_i       (w_pop & ~w_fifo_empty),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

endmodule

// File: tb/tb_sp_ram_req_adapter.sv
// Bench for sp_ram_req_adapter: a behavioural RAM on the macro side, a
// transaction-level reference model (queue of expected responses plus a
// shadow memory) and directed plus randomized scenarios.
module tb_sp_ram_req_adapter;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 2;
`ifdef SP_RAM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk;
    logic          rstn_i;
    logic          req_i;
    logic          gnt_o;
    logic [AW-1:0] addr_i;
    logic          we_i;
    logic [BW-1:0] be_i;
    logic [DW-1:0] wdata_i;
    logic          rvalid_o;
    logic          rready_i;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    sp_ram_req_adapter dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 2 KiB macro: only byte-address bits [10:2] select a word.
    logic [DW-1:0] ram_mem [512];
    bit            ram_inited = 1'b0;
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 512; i++) ram_mem[i] <= '0;
            ram_inited <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be_o[b]) ram_mem[ram_addr_o[10:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o[10:2]];
            end
        end
    end

    // Reference model state.
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            gcyc;
    } exp_t;

    typedef struct packed {
        logic          gnt;
        logic          ram_en;
        logic          ram_we;
        logic          rvalid;
        logic          err;
        logic [DW-1:0] rdata;
        logic [AW-1:0] ram_addr;
        logic [BW-1:0] ram_be;
        logic [DW-1:0] ram_wdata;
    } obs_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [512];
    int            cyc;
    int            total;
    int            bad;

    // One clock cycle: drive a request, sample the DUT, predict, advance the model.
    task automatic step(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [BW-1:0] be, input logic [DW-1:0] wdata,
                        input logic rready, output obs_t o, output obs_t e);
        logic oob;
        exp_t ent;
        @(negedge clk);
        req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata; rready_i = rready;
        #1;
        o.gnt = gnt_o; o.ram_en = ram_en_o; o.ram_we = ram_we_o; o.rvalid = rvalid_o;
        o.err = err_o; o.rdata = rdata_o; o.ram_addr = ram_addr_o; o.ram_be = ram_be_o;
        o.ram_wdata = ram_wdata_o;
        e = '0;
        e.rvalid = (q.size() > 0) && (q[0].gcyc < cyc);
        if (e.rvalid) begin
            e.rdata = q[0].rdata;
            e.err   = q[0].err;
        end
        oob         = CHK && (addr[14:11] != 4'd0);
        e.gnt       = req && (q.size() < DEPTH);
        e.ram_en    = e.gnt && !oob;
        e.ram_we    = e.ram_en && we;
        e.ram_addr  = addr;
        e.ram_be    = be;
        e.ram_wdata = wdata;
        if (e.rvalid && rready) void'(q.pop_front());
        if (e.gnt) begin
            ent.gcyc  = cyc;
            ent.err   = oob;
            ent.rdata = (oob || we) ? '0 : ref_mem[addr[10:2]];
            if (!oob && we)
                for (int b = 0; b < BW; b++)
                    if (be[b]) ref_mem[addr[10:2]][8*b +: 8] = wdata[8*b +: 8];
            q.push_back(ent);
            $display("txn cyc=%0d %s addr=%h be=%h wdata=%h", cyc, we ? "WR" : "RD", addr, be, wdata);
        end
        cyc++;
    endtask

    // Idle cycles with rready high to empty the pipeline.
    task automatic drain(input int n);
        obs_t o, e;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, o, e);
    endtask

    task automatic test_reset();
        obs_t o, e;
        rstn_i = 1'b0; req_i = 1'b1; we_i = 1'b1; addr_i = '0; be_i = '1; wdata_i = '1; rready_i = 1'b1;
        #7;
        total++; if (gnt_o !== 1'b0)    begin bad++; $display("FAIL rst_gnt got=%b exp=0", gnt_o); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", rvalid_o); end
        total++; if (rdata_o !== '0)    begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
        total++; if (err_o !== 1'b0)    begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
        total++; if (ram_en_o !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%b exp=0", ram_en_o); end
        total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%b exp=0", ram_we_o); end
        @(negedge clk);
        rstn_i = 1'b1;
        req_i  = 1'b0;
        step(1'b1, 1'b0, 15'h000, 4'hF, '0, 1'b1, o, e);
        total++; if (o.gnt !== 1'b1) begin bad++; $display("FAIL rst_first_gnt got=%b exp=1", o.gnt); end
        drain(2);
    endtask

    task automatic test_write_read();
        obs_t o, e;
        step(1'b1, 1'b1, 15'h010, 4'hF, 32'hCAFEF00D, 1'b1, o, e);
        total++; if (o.gnt !== 1'b1 || o.ram_we !== 1'b1 || o.ram_en !== 1'b1)
            begin bad++; $display("FAIL wr_grant got gnt=%b en=%b we=%b exp=1/1/1", o.gnt, o.ram_en, o.ram_we); end
        step(1'b1, 1'b0, 15'h010, 4'hF, '0, 1'b1, o, e);
        total++; if (o.rvalid !== 1'b1 || o.rdata !== 32'h0)
            begin bad++; $display("FAIL wr_rsp got v=%b d=%h exp v=1 d=0", o.rvalid, o.rdata); end
        total++; if (o.gnt !== 1'b1) begin bad++; $display("FAIL rd_grant got=%b exp=1", o.gnt); end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, o, e);
        total++; if (o.rvalid !== 1'b1 || o.rdata !== 32'hCAFEF00D || o.err !== 1'b0)
            begin bad++; $display("FAIL rd_rsp got v=%b d=%h e=%b exp v=1 d=cafef00d e=0", o.rvalid, o.rdata, o.err); end
        drain(2);
    endtask

    task automatic test_backpressure();
        obs_t o, e;
        logic [DW-1:0] got [3];
        logic [DW-1:0] want [3];
        int npop;
        bit granted;
        want[0] = 32'h11111111; want[1] = 32'h22222222; want[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, AW'(i * 4), 4'hF, want[i], 1'b1, o, e);
        drain(2);
        step(1'b1, 1'b0, 15'h000, 4'hF, '0, 1'b0, o, e);
        total++; if (o.gnt !== 1'b1) begin bad++; $display("FAIL bp_gnt0 got=%b exp=1", o.gnt); end
        step(1'b1, 1'b0, 15'h004, 4'hF, '0, 1'b0, o, e);
        total++; if (o.gnt !== 1'b1) begin bad++; $display("FAIL bp_gnt1 got=%b exp=1", o.gnt); end
        step(1'b1, 1'b0, 15'h008, 4'hF, '0, 1'b0, o, e);
        total++; if (o.gnt !== 1'b0) begin bad++; $display("FAIL bp_gnt2 got=%b exp=0", o.gnt); end
        total++; if (o.rvalid !== 1'b1 || o.rdata !== want[0])
            begin bad++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h", o.rvalid, o.rdata, want[0]); end
        npop = 0;
        granted = 1'b0;
        for (int i = 0; i < 12 && npop < 3; i++) begin
            step(!granted, 1'b0, 15'h008, 4'hF, '0, 1'b1, o, e);
            if (o.rvalid) begin
                if (npop < 3) got[npop] = o.rdata;
                npop++;
            end
            if (o.gnt) granted = 1'b1;
        end
        total++; if (npop !== 3) begin bad++; $display("FAIL bp_pops got=%0d exp=3", npop); end
        for (int i = 0; i < 3 && i < npop; i++) begin
            total++; if (got[i] !== want[i])
                begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], want[i]); end
        end
        drain(2);
    endtask

    task automatic test_streaming();
        obs_t o, e;
        logic [9:0] gnt_bits;
        logic [9:0] vld_bits;
        for (int i = 0; i < 10; i++) begin
            step(i < 8, 1'b0, AW'(i * 4), 4'hF, '0, 1'b1, o, e);
            gnt_bits[i] = o.gnt;
            vld_bits[i] = o.rvalid;
            total++; if (o.rvalid && o.rdata !== e.rdata)
                begin bad++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, o.rdata, e.rdata); end
        end
        total++; if (gnt_bits !== 10'b00_1111_1111)
            begin bad++; $display("FAIL stream_gnt got=%b exp=0011111111", gnt_bits); end
        total++; if (vld_bits !== 10'b01_1111_1110)
            begin bad++; $display("FAIL stream_rvalid got=%b exp=0111111110", vld_bits); end
    endtask

    task automatic test_out_of_range();
        obs_t o, e;
        step(1'b1, 1'b1, 15'h000, 4'hF, 32'h5A5AA5A5, 1'b1, o, e);
        drain(2);
        step(1'b1, 1'b0, 15'h4000, 4'hF, '0, 1'b1, o, e);
        total++; if (o.gnt !== 1'b1) begin bad++; $display("FAIL oob_gnt got=%b exp=1", o.gnt); end
        total++; if (o.ram_en !== !CHK) begin bad++; $display("FAIL oob_ram_en got=%b exp=%b", o.ram_en, !CHK); end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, o, e);
        if (CHK) begin
            total++; if (o.rvalid !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'h0)
                begin bad++; $display("FAIL oob_rsp got v=%b e=%b d=%h exp v=1 e=1 d=0", o.rvalid, o.err, o.rdata); end
        end else begin
            total++; if (o.rvalid !== 1'b1 || o.err !== 1'b0 || o.rdata !== 32'h5A5AA5A5)
                begin bad++; $display("FAIL oob_wrap got v=%b e=%b d=%h exp v=1 e=0 d=5a5aa5a5", o.rvalid, o.err, o.rdata); end
        end
        drain(2);
    endtask

    task automatic test_mid_reset();
        obs_t o, e;
        step(1'b1, 1'b0, 15'h000, 4'hF, '0, 1'b0, o, e);
        step(1'b1, 1'b0, 15'h004, 4'hF, '0, 1'b0, o, e);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 15'h008; rready_i = 1'b0;
        #1;
        total++; if (rvalid_o !== 1'b1) begin bad++; $display("FAIL mrst_pre_valid got=%b exp=1", rvalid_o); end
        rstn_i = 1'b0;
        #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL mrst_rvalid got=%b exp=0", rvalid_o); end
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL mrst_gnt got=%b exp=0", gnt_o); end
        q.delete();
        cyc++;
        @(posedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
        req_i  = 1'b0;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1, o, e);
            total++; if (o.rvalid !== 1'b0) begin bad++; $display("FAIL mrst_stale i=%0d got=%b exp=0", i, o.rvalid); end
        end
        step(1'b1, 1'b0, 15'h004, 4'hF, '0, 1'b1, o, e);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, o, e);
        total++; if (o.rvalid !== 1'b1 || o.rdata !== 32'h22222222)
            begin bad++; $display("FAIL mrst_read got v=%b d=%h exp v=1 d=22222222", o.rvalid, o.rdata); end
        drain(2);
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [AW-1:0] a;
        for (int i = 0; i < 400; i++) begin
            a = AW'($urandom_range(0, 511)) << 2;
            if ($urandom_range(0, 9) == 0) a[14:11] = 4'($urandom_range(1, 15));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, 4'($urandom),
                 $urandom, $urandom_range(0, 9) < 6, o, e);
            total++; if (o.gnt !== e.gnt)
                begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, o.gnt, e.gnt); end
            total++; if (o.ram_en !== e.ram_en || o.ram_we !== e.ram_we)
                begin bad++; $display("FAIL rnd_ram_ctl cyc=%0d got=%b%b exp=%b%b", cyc, o.ram_en, o.ram_we, e.ram_en, e.ram_we); end
            total++; if (o.rvalid !== e.rvalid || o.rdata !== e.rdata || o.err !== e.err)
                begin bad++; $display("FAIL rnd_rsp cyc=%0d got v=%b d=%h e=%b exp v=%b d=%h e=%b",
                                      cyc, o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err); end
            if (e.gnt) begin
                total++; if (o.ram_addr !== e.ram_addr || o.ram_be !== e.ram_be || o.ram_wdata !== e.ram_wdata)
                    begin bad++; $display("FAIL rnd_ram_bus cyc=%0d got a=%h b=%h w=%h exp a=%h b=%h w=%h",
                                          cyc, o.ram_addr, o.ram_be, o.ram_wdata, e.ram_addr, e.ram_be, e.ram_wdata); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1, o, e);
            total++; if (o.rvalid !== e.rvalid || o.rdata !== e.rdata)
                begin bad++; $display("FAIL rnd_drain i=%0d got v=%b d=%h exp v=%b d=%h", i, o.rvalid, o.rdata, e.rvalid, e.rdata); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_streaming();
        test_out_of_range();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_ram_req_adapter.md
SP_RAM_REQ_ADAPTER -- requirements
Module: sp_ram_req_adapter

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 15: request byte-address width (32 KiB space).
- DATA_WIDTH, 32: data width.
- RAM_ADDR_WIDTH, 11: byte-address bits decoded by the 2 KiB macro.
- RSP_DEPTH, 2: response buffer entries.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response consumed.
- rdata_o  out  DATA_WIDTH  read data; 0 for writes.
- err_o  out  1  response error flag.
- ram_en_o  out  1  RAM access strobe.
- ram_we_o  out  1  RAM write, active-high.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read.

Function
REQ-003 outstanding SHALL equal in-flight (0/1) plus buffer occupancy, and never exceed RSP_DEPTH.
REQ-004 gnt_o SHALL be req_i & (outstanding < RSP_DEPTH), evaluated without crediting a same-cycle pop.
REQ-005 In a grant cycle N, ram_en_o SHALL be 1 and ram_addr_o/ram_be_o/ram_wdata_o SHALL equal addr_i/be_i/wdata_i combinationally. ram_we_o SHALL equal we_i.
REQ-006 In non-grant cycles, ram_en_o and ram_we_o SHALL be 0.
REQ-007 The response for a grant in cycle N SHALL be formed in cycle N+1:
- read: rdata = ram_rdata_i.
- write: rdata = 0.
- err = 0.
REQ-008 When the buffer is empty, the N+1 response SHALL fall through combinationally to rvalid_o/rdata_o/err_o.
REQ-009 If the fall-through response is not popped in N+1, or the buffer is non-empty, the response SHALL be written to the buffer tail.
REQ-010 rvalid_o SHALL be 1 when the buffer is non-empty or a fall-through response is present. Responses SHALL be delivered in order.
REQ-011 A pop SHALL occur on rvalid_o & rready_i. Response data SHALL stay stable while rvalid_o=1 and rready_i=0.
REQ-012 A simultaneous push and pop on a full buffer cannot occur (guaranteed by REQ-004). A simultaneous push and pop on a non-full buffer SHALL leave occupancy unchanged.
REQ-013 With rready_i held at 1, sustained throughput SHALL be one request per cycle, with one cycle of read latency.
REQ-014 Buffer pointers SHALL wrap modulo RSP_DEPTH.

Reset
REQ-015 While rstn_i=0, the following SHALL be 0: gnt_o, rvalid_o, rdata_o, err_o, ram_en_o, ram_we_o.
REQ-016 Reset SHALL clear the in-flight flag, buffer pointers and occupancy. In-flight and buffered responses SHALL be discarded.
REQ-017 gnt_o SHALL be 0 during reset. Granting SHALL resume in the first cycle after deassertion.

Configuration
REQ-018 Macro SP_RAM_ADDR_CHECK_EN controls out-of-range address checking.
- Defined: a request with addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH] != 0 SHALL be granted under REQ-004 with ram_en_o=0 and ram_we_o=0. Its response SHALL be rdata=0, err=1 at the same N+1 timing.
- Undefined: upper address bits SHALL be ignored (the address wraps inside the macro), and err_o SHALL be tied 0.

Structure
REQ-019 Package sp_ram_pkg SHALL hold:
- the response struct {rdata, err};
- RSP_DEPTH_DEFAULT;
- RAM_ADDR_WIDTH_DEFAULT.
REQ-020 The response buffer SHALL be sub-module sp_ram_rsp_fifo: parameterised depth, push/pop/full/empty, asynchronous active-low reset on clk.

Verification
REQ-021 Write then read back: write 0xCAFEF00D to 0x010 with be=4'hF, then read 0x010 (rready=1).
- Write response rdata=0 in N+1.
- Read response rdata=0xCAFEF00D in M+1.
REQ-022 Backpressure: hold rready=0 and issue 3 reads of 0x000/0x004/0x008.
- Only 2 grants occur. gnt_o=0 on the 3rd request.
- After 3 pops, all 3 responses arrive in order.
REQ-023 Streaming: issue 8 back-to-back reads with rready=1.
- gnt_o=1 for 8 consecutive cycles.
- rvalid_o=1 for 8 consecutive cycles starting at N+1.
REQ-024 Out-of-range, macro defined: read 0x4000.
- ram_en_o=0.
- Response err_o=1, rdata_o=0.
- Macro undefined: the same read returns the contents of 0x000 with err_o=0.
REQ-025 Reset mid-operation: 2 responses buffered and 1 in flight, then assert rstn_i.
- rvalid_o=0 immediately.
- After deassertion, there are no stale responses and the first new read returns correct data.
